// File: rtl/sort_pkg.sv
// sort_pkg: constants and state type shared by the 8-entry sorter and its read-side streamer.
package sort_pkg;
    localparam int NUM_ELEMS = 8;
    localparam int IDX_W = 3;
    typedef enum logic {IDLE, STREAM} stream_state_t;
endpackage

// File: rtl/sorted_vec_next_sel.sv
// sorted_vec_next_sel: picks the next slot to present and whether it ends the stream.
// mask_i marks unemitted slots; mask_i[NUM_ELEMS-1] set means nothing has been emitted yet.
module sorted_vec_next_sel
    import sort_pkg::*;
#(
    parameter int BITWIDTH = 3
) (
    input  logic [IDX_W-1:0]              idx_i,
    input  logic [NUM_ELEMS-1:0]          mask_i,
    input  logic [NUM_ELEMS*BITWIDTH-1:0] slots_i,
    output logic [IDX_W-1:0]              nxt_idx_o,
    output logic [BITWIDTH-1:0]           nxt_val_o,
    output logic                          last_o
);
`ifdef SORTED_VEC_STREAMER_DEDUP_EN
    logic [BITWIDTH-1:0] cur;
    logic [NUM_ELEMS-1:0] tail;
    always_comb begin
        cur = slots_i[idx_i*BITWIDTH +: BITWIDTH];
        nxt_idx_o = '0;
        tail = '0;
        for (int j = 0; j < NUM_ELEMS; j++)
            if (mask_i[j] && (mask_i[NUM_ELEMS-1] || slots_i[j*BITWIDTH +: BITWIDTH] != cur))
                nxt_idx_o = IDX_W'(j);
        nxt_val_o = slots_i[nxt_idx_o*BITWIDTH +: BITWIDTH];
        // last when nothing distinct remains below the chosen slot
        for (int j = 0; j < NUM_ELEMS; j++)
            tail[j] = mask_i[j] && (IDX_W'(j) < nxt_idx_o) && (slots_i[j*BITWIDTH +: BITWIDTH] != nxt_val_o);
        last_o = ~|tail;
    end
`else
    always_comb begin
        nxt_idx_o = mask_i[NUM_ELEMS-1] ? IDX_W'(NUM_ELEMS-1) : idx_i - 1'b1;
        nxt_val_o = slots_i[nxt_idx_o*BITWIDTH +: BITWIDTH];
        last_o = ~|(mask_i & ~(NUM_ELEMS'(1) << nxt_idx_o));
    end
`endif
endmodule

// File: rtl/sorted_vec_streamer.sv
// sorted_vec_streamer: captures a sorted 8-slot vector and streams it smallest-first over valid/ready.
// Define SORTED_VEC_STREAMER_DEDUP_EN to skip elements equal to the previously emitted one.
module sorted_vec_streamer
    import sort_pkg::*;
#(
    parameter int BITWIDTH = 3
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_ELEMS*BITWIDTH-1:0] din_vec,
    input  logic                          load,
    output logic                          busy,
    output logic [BITWIDTH-1:0]           dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          dout_last
);
    stream_state_t state_q, state_d;
    logic [NUM_ELEMS*BITWIDTH-1:0] slots_q, slots_d, sel_slots;
    logic [IDX_W-1:0] idx_q, idx_d, nxt_idx;
    logic [BITWIDTH-1:0] dout_q, dout_d, nxt_val;
    logic [NUM_ELEMS-1:0] mask;
    logic last_q, last_d, nxt_last, accept, hs, adv;

    assign accept = (state_q == IDLE) && load;
    assign hs = (state_q == STREAM) && dout_ready;
    assign adv = accept || (hs && !last_q);
    assign sel_slots = accept ? din_vec : slots_q;

    // remaining slots are those below the presented index, or all of them on capture
    always_comb begin
        mask = '0;
        for (int j = 0; j < NUM_ELEMS; j++)
            mask[j] = accept || (IDX_W'(j) < idx_q);
    end

    sorted_vec_next_sel #(.BITWIDTH(BITWIDTH)) u_next_sel (
        .idx_i    (idx_q),
        .mask_i   (mask),
        .slots_i  (sel_slots),
        .nxt_idx_o(nxt_idx),
        .nxt_val_o(nxt_val),
        .last_o   (nxt_last)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            slots_q <= '0;
            idx_q   <= IDX_W'(NUM_ELEMS-1);
            dout_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slots_q <= slots_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            last_q  <= last_d;
        end
    end

    always_comb state_d = accept ? STREAM : (hs && last_q) ? IDLE : state_q;

    always_comb begin
        slots_d = sel_slots;
        idx_d   = adv ? nxt_idx : idx_q;
        dout_d  = adv ? nxt_val : dout_q;
        last_d  = adv ? nxt_last : hs ? 1'b0 : last_q;
    end

    always_comb begin
        busy       = state_q == STREAM;
        dout_valid = state_q == STREAM;
        dout       = dout_q;
        dout_last  = last_q;
    end
endmodule

// File: tb/tb_sorted_vec_streamer.sv
// tb_sorted_vec_streamer: randomized self-checking bench against a slot-order reference model.
module tb_sorted_vec_streamer;
    localparam int BW = 3;
    localparam int VW = 8 * BW;

    logic clk = 1'b0, resetn = 1'b0, load = 1'b0, dout_ready = 1'b0;
    logic [VW-1:0] din_vec = '0;
    logic busy, dout_valid, dout_last;
    logic [BW-1:0] dout;
    int checks = 0, errors = 0;
    logic [BW-1:0] exp_val[8];
    int exp_n;
    logic [BW-1:0] got_val[16];
    logic got_last[16];
    int got_n;

    always #5 clk = ~clk;

    sorted_vec_streamer #(.BITWIDTH(BW)) dut (
        .clk(clk), .resetn(resetn), .din_vec(din_vec), .load(load), .busy(busy),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] pack(input int s[8]);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[k*BW +: BW] = BW'(s[k]);
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec(input int maxv);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[k*BW +: BW] = BW'($urandom_range(maxv));
        return v;
    endfunction

    // expected stream: slot 7 down to slot 0, optionally dropping repeats of the last emitted value
    function automatic void build_model(input logic [VW-1:0] v);
        logic [BW-1:0] x;
        exp_n = 0;
        for (int k = 7; k >= 0; k--) begin
            x = v[k*BW +: BW];
`ifdef SORTED_VEC_STREAMER_DEDUP_EN
            if (exp_n > 0 && x == exp_val[exp_n-1]) continue;
`endif
            exp_val[exp_n] = x;
            exp_n++;
        end
    endfunction

    task automatic do_load(input logic [VW-1:0] v);
        din_vec = v;
        load = 1'b1;
        step;
        load = 1'b0;
        din_vec = VW'($urandom);
    endtask

    task automatic collect(input int pct);
        got_n = 0;
        for (int c = 0; c < 200 && got_n < 16; c++) begin
            dout_ready = ($urandom_range(99) < pct);
            if (dout_valid && dout_ready) begin
                got_val[got_n] = dout;
                got_last[got_n] = dout_last;
                got_n++;
                if (dout_last) begin
                    step;
                    dout_ready = 1'b0;
                    return;
                end
            end
            step;
        end
        dout_ready = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        step;
        step;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
        checks++; if (dout_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", dout_last); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got %0d exp 0", dout); end
        resetn = 1'b1;
        step;
    endtask

    task automatic test_basic;
        int s[8];
        logic [VW-1:0] v;
        s = '{7, 6, 5, 4, 3, 2, 1, 0};
        v = pack(s);
        build_model(v);
        dout_ready = 1'b1;
        do_load(v);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({busy, dout_valid, dout, dout_last} !== {1'b1, 1'b1, BW'(i), i == 7}) begin
                errors++;
                $display("FAIL basic_beat%0d got busy=%b v=%b d=%0d l=%b exp 1/1/%0d/%b", i, busy, dout_valid, dout, dout_last, i, i == 7);
            end
            step;
        end
        dout_ready = 1'b0;
        checks++;
        if ({busy, dout_valid, dout_last, dout} !== {3'b000, BW'(7)}) begin
            errors++;
            $display("FAIL basic_end got busy=%b v=%b l=%b d=%0d exp 0/0/0/7", busy, dout_valid, dout_last, dout);
        end
    endtask

    task automatic test_backpressure;
        int s[8];
        int beat = 0, hold = 0;
        s = '{7, 6, 5, 4, 3, 2, 1, 0};
        build_model(pack(s));
        do_load(pack(s));
        for (int c = 0; c < 30 && beat < 8; c++) begin
            dout_ready = !(beat == 2 && hold < 3);
            if (!dout_ready) begin
                checks++;
                if (dout !== BW'(2) || dout_valid !== 1'b1 || dout_last !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_hold%0d got d=%0d v=%b l=%b exp 2/1/0", hold, dout, dout_valid, dout_last);
                end
                hold++;
            end else if (dout_valid) begin
                checks++;
                if (dout !== exp_val[beat] || dout_last !== (beat == 7)) begin
                    errors++;
                    $display("FAIL bp_beat%0d got %0d/%b exp %0d/%b", beat, dout, dout_last, exp_val[beat], beat == 7);
                end
                beat++;
            end
            step;
        end
        dout_ready = 1'b0;
        checks++;
        if (beat != 8 || hold != 3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_count got beats=%0d holds=%0d busy=%b exp 8/3/0", beat, hold, busy);
        end
    endtask

    task automatic test_load_busy;
        logic [VW-1:0] va, vc;
        int beat = 0;
        va = rand_vec(7);
        vc = rand_vec(7);
        build_model(va);
        dout_ready = 1'b1;
        do_load(va);
        for (int c = 0; c < 20; c++) begin
            load = (beat == 3) || (dout_valid && dout_last);
            din_vec = rand_vec(7);
            if (dout_valid) begin
                checks++;
                if (beat >= exp_n || dout !== exp_val[beat] || dout_last !== (beat == exp_n - 1)) begin
                    errors++;
                    $display("FAIL lb_beat%0d got %0d/%b exp %0d/%b", beat, dout, dout_last, exp_val[beat % 8], beat == exp_n - 1);
                end
                beat++;
            end
            if (dout_valid && dout_last) begin
                step;
                break;
            end
            step;
        end
        load = 1'b0;
        dout_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || beat != exp_n) begin
            errors++;
            $display("FAIL lb_end got busy=%b beats=%0d exp 0/%0d", busy, beat, exp_n);
        end
        build_model(vc);
        do_load(vc);
        collect(100);
        checks++;
        if (got_n != exp_n) begin errors++; $display("FAIL lb_restart_len got %0d exp %0d", got_n, exp_n); end
        for (int i = 0; i < exp_n && i < got_n; i++) begin
            checks++;
            if (got_val[i] !== exp_val[i] || got_last[i] !== (i == exp_n - 1)) begin
                errors++;
                $display("FAIL lb_restart%0d got %0d/%b exp %0d/%b", i, got_val[i], got_last[i], exp_val[i], i == exp_n - 1);
            end
        end
    endtask

    task automatic test_reset_mid;
        int s[8];
        int r;
        logic [VW-1:0] vb;
        r = $urandom_range(7);
        for (int k = 0; k < 8; k++) s[k] = (k + r) % 8;
        dout_ready = 1'b1;
        do_load(pack(s));
        for (int i = 0; i < 4; i++) step;
        dout_ready = 1'b0;
        resetn = 1'b0;
        step;
        resetn = 1'b1;
        checks++;
        if ({busy, dout_valid, dout_last, dout} !== {3'b000, BW'(0)}) begin
            errors++;
            $display("FAIL rst_mid got busy=%b v=%b l=%b d=%0d exp 0/0/0/0", busy, dout_valid, dout_last, dout);
        end
        vb = rand_vec(7);
        build_model(vb);
        do_load(vb);
        collect(70);
        checks++;
        if (got_n != exp_n) begin errors++; $display("FAIL rst_mid_len got %0d exp %0d", got_n, exp_n); end
        for (int i = 0; i < exp_n && i < got_n; i++) begin
            checks++;
            if (got_val[i] !== exp_val[i] || got_last[i] !== (i == exp_n - 1)) begin
                errors++;
                $display("FAIL rst_mid%0d got %0d/%b exp %0d/%b", i, got_val[i], got_last[i], exp_val[i], i == exp_n - 1);
            end
        end
    endtask

    task automatic test_duplicates;
        int s[8];
        int want_n;
        s = '{5, 5, 3, 3, 3, 1, 0, 0};
`ifdef SORTED_VEC_STREAMER_DEDUP_EN
        want_n = 4;
`else
        want_n = 8;
`endif
        build_model(pack(s));
        do_load(pack(s));
        collect(100);
        checks++;
        if (got_n != want_n) begin errors++; $display("FAIL dup_len got %0d exp %0d", got_n, want_n); end
        for (int i = 0; i < exp_n && i < got_n; i++) begin
            checks++;
            if (got_val[i] !== exp_val[i] || got_last[i] !== (i == exp_n - 1)) begin
                errors++;
                $display("FAIL dup%0d got %0d/%b exp %0d/%b", i, got_val[i], got_last[i], exp_val[i], i == exp_n - 1);
            end
        end
    endtask

    task automatic test_all_equal;
        int s[8];
        int want_n;
        for (int k = 0; k < 8; k++) s[k] = 6;
`ifdef SORTED_VEC_STREAMER_DEDUP_EN
        want_n = 1;
`else
        want_n = 8;
`endif
        do_load(pack(s));
        collect(100);
        checks++;
        if (got_n != want_n) begin errors++; $display("FAIL eq_len got %0d exp %0d", got_n, want_n); end
        for (int i = 0; i < got_n && i < want_n; i++) begin
            checks++;
            if (got_val[i] !== BW'(6) || got_last[i] !== (i == want_n - 1)) begin
                errors++;
                $display("FAIL eq%0d got %0d/%b exp 6/%b", i, got_val[i], got_last[i], i == want_n - 1);
            end
        end
    endtask

    task automatic test_random;
        logic [VW-1:0] v;
        for (int t = 0; t < 25; t++) begin
            v = rand_vec((t % 2 == 0) ? 3 : 7);
            build_model(v);
            for (int g = $urandom_range(2); g > 0; g--) step;
            do_load(v);
            collect(60);
            checks++;
            if (got_n != exp_n) begin errors++; $display("FAIL rand%0d_len got %0d exp %0d", t, got_n, exp_n); end
            for (int i = 0; i < exp_n && i < got_n; i++) begin
                checks++;
                if (got_val[i] !== exp_val[i] || got_last[i] !== (i == exp_n - 1)) begin
                    errors++;
                    $display("FAIL rand%0d_beat%0d got %0d/%b exp %0d/%b", t, i, got_val[i], got_last[i], exp_val[i], i == exp_n - 1);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_load_busy;
        test_reset_mid;
        test_duplicates;
        test_all_equal;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
